tnoc_packet_packer: RTL and testbench

TNOC_PACKET_PACKER -- requirements
Module: tnoc_packet_packer

---
 rtl/tnoc_packet_packer_pkg.sv | 122 ++++++++++++
 rtl/tnoc_packet_packer_if.sv | 36 +++
 rtl/tnoc_packet_packer.sv | 149 ++++++++++++++
 tb/tb_tnoc_packet_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tnoc_packet_packer_pkg.sv
// Shared NoC definitions: configuration, packet/flit layouts and the packing
// helpers used by the packet packer.
package tnoc_packet_packer_pkg;

  typedef struct packed {
    int virtual_channels;
    int address_width;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2, address_width: 32};

  typedef enum logic {
    TNOC_LOCAL_PORT    = 1'b0,
    TNOC_INTERNAL_PORT = 1'b1
  } tnoc_port_type;

  typedef enum logic {
    TNOC_HEADER_FLIT  = 1'b0,
    TNOC_PAYLOAD_FLIT = 1'b1
  } tnoc_flit_type;

  localparam int TNOC_FLIT_DATA_WIDTH = 40;

  // Bit 4 marks a request, bit 0 marks a packet that carries payload.
  localparam logic [7:0] TNOC_READ          = 8'h10;
  localparam logic [7:0] TNOC_WRITE         = 8'h11;
  localparam logic [7:0] TNOC_RESPONSE      = 8'h20;
  localparam logic [7:0] TNOC_READ_RESPONSE = 8'h21;

  typedef struct packed {
    logic [7:0]  packet_type;
    logic [3:0]  destination_id;
    logic [3:0]  source_id;
    logic [1:0]  vc;
    logic [5:0]  tag;
    logic [31:0] address;
    logic [8:0]  burst_length;
    logic [1:0]  status;
  } tnoc_packet_header;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  byte_enable;
    logic [1:0]  status;
    logic        response_last;
  } tnoc_packet_payload;

  typedef struct packed {
    logic [5:0] tag;
    logic [1:0] vc;
    logic [3:0] source_id;
    logic [3:0] destination_id;
    logic [7:0] packet_type;
  } tnoc_common_header_fields;

  typedef struct packed {
    logic [7:0]  burst_length;
    logic [31:0] address;
  } tnoc_request_header_fields;

  typedef struct packed {
    logic [1:0] status;
  } tnoc_response_header_fields;

  typedef struct packed {
    logic [3:0]  byte_enable;
    logic [31:0] data;
  } tnoc_write_payload;

  typedef struct packed {
    logic        response_last;
    logic [1:0]  status;
    logic [31:0] data;
  } tnoc_read_payload;

  typedef struct packed {
    tnoc_flit_type                   flit_type;
    logic                            head;
    logic                            tail;
    logic [TNOC_FLIT_DATA_WIDTH-1:0] data;
  } tnoc_flit;

  localparam int TNOC_COMMON_HEADER_WIDTH   = $bits(tnoc_common_header_fields);
  localparam int TNOC_REQUEST_HEADER_WIDTH  = $bits(tnoc_request_header_fields);
  localparam int TNOC_RESPONSE_HEADER_WIDTH = $bits(tnoc_response_header_fields);
  localparam int TNOC_WRITE_PAYLOAD_WIDTH   = $bits(tnoc_write_payload);
  localparam int TNOC_READ_PAYLOAD_WIDTH    = $bits(tnoc_read_payload);

  function automatic int calc_request_header_flits();
    return (TNOC_COMMON_HEADER_WIDTH + TNOC_REQUEST_HEADER_WIDTH + TNOC_FLIT_DATA_WIDTH - 1)
           / TNOC_FLIT_DATA_WIDTH;
  endfunction

  function automatic int calc_response_header_flits();
    return (TNOC_COMMON_HEADER_WIDTH + TNOC_RESPONSE_HEADER_WIDTH + TNOC_FLIT_DATA_WIDTH - 1)
           / TNOC_FLIT_DATA_WIDTH;
  endfunction

  function automatic int calc_header_flits();
    int req_flits;
    int rsp_flits;
    req_flits = calc_request_header_flits();
    rsp_flits = calc_response_header_flits();
    return (req_flits > rsp_flits) ? req_flits : rsp_flits;
  endfunction

  // Burst length 1..256 travels as length-1 in eight bits.
  function automatic logic [7:0] pack_burst_length(input logic [8:0] burst_length);
    logic [8:0] minus_one;
    minus_one = burst_length - 9'd1;
    return minus_one[7:0];
  endfunction

  function automatic logic is_request_packet(input logic [7:0] packet_type);
    return packet_type[4];
  endfunction

  function automatic logic is_header_only_packet(input logic [7:0] packet_type);
    return !packet_type[0];
  endfunction

endpackage

// File: rtl/tnoc_packet_packer_if.sv
// Packet-level endpoint interface and flit-level link interface.
interface tnoc_packet_if;
  import tnoc_packet_packer_pkg::*;

  logic               header_valid;
  logic               header_ready;
  tnoc_packet_header  header;
  logic               payload_valid;
  logic               payload_ready;
  tnoc_packet_payload payload;
  logic               payload_last;

  modport initiator (
    output header_valid, input header_ready, output header,
    output payload_valid, input payload_ready, output payload, output payload_last
  );

  modport target (
    input header_valid, output header_ready, input header,
    input payload_valid, output payload_ready, input payload, input payload_last
  );
endinterface

interface tnoc_flit_if #(
  parameter int CHANNELS = 2
);
  import tnoc_packet_packer_pkg::*;

  logic [CHANNELS-1:0] valid;
  logic [CHANNELS-1:0] ready;
  tnoc_flit            flit;
  logic [CHANNELS-1:0] vc_available;

  modport initiator (output valid, input ready, output flit, input vc_available);
  modport target    (input valid, output ready, input flit, output vc_available);
endinterface

// File: rtl/tnoc_packet_packer.sv
// Serializes a packet header plus payload beats into flits on one lane,
// steering valid onto the packet's virtual channel.
module tnoc_packet_packer
  import tnoc_packet_packer_pkg::*;
#(
  parameter tnoc_config    CONFIG    = TNOC_DEFAULT_CONFIG,
  parameter int            CHANNELS  = CONFIG.virtual_channels,
  parameter tnoc_port_type PORT_TYPE = TNOC_LOCAL_PORT
)(
  input  logic           clk,
  input  logic           rst_n,
  tnoc_packet_if.target  packet_in_if,
  tnoc_flit_if.initiator flit_out_if
);

  localparam int FLIT_W                = TNOC_FLIT_DATA_WIDTH;
  localparam int REQUEST_HEADER_FLITS  = calc_request_header_flits();
  localparam int RESPONSE_HEADER_FLITS = calc_response_header_flits();
  localparam int HEADER_FLITS          = calc_header_flits();
  localparam int COUNT_W               = (HEADER_FLITS > 1) ? $clog2(HEADER_FLITS) : 1;
  localparam int VC_W                  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [COUNT_W-1:0] LAST_REQUEST_COUNT  = COUNT_W'(REQUEST_HEADER_FLITS - 1);
  localparam logic [COUNT_W-1:0] LAST_RESPONSE_COUNT = COUNT_W'(RESPONSE_HEADER_FLITS - 1);

  localparam logic [0:0] HEADER  = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  logic [0:0]         r_state;
  logic [COUNT_W-1:0] r_count;
  logic [VC_W-1:0]    r_vc;
  logic               r_write_payload;

  tnoc_common_header_fields          w_common;
  tnoc_request_header_fields         w_request_fields;
  tnoc_response_header_fields        w_response_fields;
  logic [HEADER_FLITS*FLIT_W-1:0]    w_header_data;
  logic [HEADER_FLITS-1:0][FLIT_W-1:0] w_header_flits;
  tnoc_write_payload                 w_write_payload;
  tnoc_read_payload                  w_read_payload;
  logic [FLIT_W-1:0]                 w_payload_data;
  tnoc_flit                          w_flit;

  logic               w_is_request;
  logic               w_header_only;
  logic [COUNT_W-1:0] w_last_count;
  logic               w_last_header;
  logic [VC_W-1:0]    w_vc;
  logic               w_valid;
  logic               w_ready;
  logic               w_accept;

  assign w_common = '{
    tag:            packet_in_if.header.tag,
    vc:             packet_in_if.header.vc,
    source_id:      packet_in_if.header.source_id,
    destination_id: packet_in_if.header.destination_id,
    packet_type:    packet_in_if.header.packet_type
  };
  assign w_request_fields = '{
    burst_length: pack_burst_length(packet_in_if.header.burst_length),
    address:      packet_in_if.header.address
  };
  assign w_response_fields = '{status: packet_in_if.header.status};

  assign w_is_request  = is_request_packet(packet_in_if.header.packet_type);
  assign w_header_only = is_header_only_packet(packet_in_if.header.packet_type);

  // Common fields sit at the LSBs; the type-specific fields follow, rest zero.
  always_comb begin
    w_header_data = '0;
    w_header_data[TNOC_COMMON_HEADER_WIDTH-1:0] = w_common;
    if (w_is_request) begin
      w_header_data[TNOC_COMMON_HEADER_WIDTH +: TNOC_REQUEST_HEADER_WIDTH] = w_request_fields;
    end else begin
      w_header_data[TNOC_COMMON_HEADER_WIDTH +: TNOC_RESPONSE_HEADER_WIDTH] = w_response_fields;
    end
  end

  assign w_header_flits = w_header_data;

  assign w_last_count  = w_is_request ? LAST_REQUEST_COUNT : LAST_RESPONSE_COUNT;
  assign w_last_header = (r_count == w_last_count);

  assign w_write_payload = '{
    byte_enable: packet_in_if.payload.byte_enable,
    data:        packet_in_if.payload.data
  };
  assign w_read_payload = '{
    response_last: packet_in_if.payload.response_last,
    status:        packet_in_if.payload.status,
    data:          packet_in_if.payload.data
  };
  assign w_payload_data = r_write_payload
    ? {{(FLIT_W-TNOC_WRITE_PAYLOAD_WIDTH){1'b0}}, w_write_payload}
    : {{(FLIT_W-TNOC_READ_PAYLOAD_WIDTH){1'b0}}, w_read_payload};

  // The head flit steers by the live header; later flits use the latched VC.
  assign w_vc     = ((r_state == HEADER) && (r_count == '0)) ? VC_W'(packet_in_if.header.vc) : r_vc;
  assign w_valid  = (r_state == HEADER) ? packet_in_if.header_valid : packet_in_if.payload_valid;
  assign w_ready  = flit_out_if.ready[w_vc];
  assign w_accept = w_valid && w_ready;

  always_comb begin
    w_flit = '0;
    if (r_state == HEADER) begin
      w_flit.flit_type = TNOC_HEADER_FLIT;
      w_flit.head      = (r_count == '0);
      w_flit.tail      = w_last_header && w_header_only;
      w_flit.data      = w_header_flits[r_count];
    end else begin
      w_flit.flit_type = TNOC_PAYLOAD_FLIT;
      w_flit.head      = 1'b0;
      w_flit.tail      = packet_in_if.payload_last;
      w_flit.data      = w_payload_data;
    end
  end

  assign flit_out_if.flit  = w_flit;
  assign flit_out_if.valid = (rst_n && w_valid) ? (CHANNELS'(1) << w_vc) : '0;

  assign packet_in_if.header_ready  = rst_n && (r_state == HEADER) && w_accept && w_last_header;
  assign packet_in_if.payload_ready = rst_n && (r_state == PAYLOAD) && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= HEADER;
      r_count         <= '0;
      r_vc            <= '0;
      r_write_payload <= 1'b0;
    end else if ((r_state == HEADER) && w_accept) begin
      if (r_count == '0) begin
        r_vc <= w_vc;
      end
      if (w_last_header) begin
        r_count         <= '0;
        r_write_payload <= w_is_request;
        if (!w_header_only) begin
          r_state <= PAYLOAD;
        end
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if ((r_state == PAYLOAD) && w_accept && packet_in_if.payload_last) begin
      r_state <= HEADER;
    end
  end

endmodule

// File: tb/tb_tnoc_packet_packer.sv
// Directed bench for the packet packer: header serialization, payload
// formatting, VC steering, backpressure, reset abort and back-to-back packets.
module tb_tnoc_packet_packer;
  import tnoc_packet_packer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  tnoc_packet_if              pkt_if ();
  tnoc_flit_if #(.CHANNELS(2)) flit_if ();

  tnoc_packet_packer #(.CHANNELS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .packet_in_if (pkt_if.target),
    .flit_out_if  (flit_if.initiator)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tnoc_packet_header rd_req_hdr, wr_req_hdr, rd_rsp_hdr, wr_rsp_hdr;

  localparam logic [39:0] RD_REQ_F0 = 40'h5678151310;
  localparam logic [39:0] RD_REQ_F1 = 40'h0000001234;
  localparam logic [39:0] WR_REQ_F0 = 40'h0040281211;
  localparam logic [39:0] WR_REQ_F1 = 40'h000003A000;
  localparam logic [39:0] RD_RSP_F0 = 40'h0002143121;
  localparam logic [39:0] WR_RSP_F0 = 40'h0001042520;

  logic [3:0]  wr_be   [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
  logic [31:0] wr_data [4] = '{32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004};
  logic [39:0] wr_flit [4] = '{40'h0FD0000001, 40'h03D0000002, 40'h0CD0000003, 40'h01D0000004};

  function automatic tnoc_packet_header make_hdr(
    input logic [7:0] ptype, input logic [3:0] dst, input logic [3:0] src,
    input logic [1:0] vc, input logic [5:0] tag, input logic [31:0] addr,
    input logic [8:0] blen, input logic [1:0] status);
    tnoc_packet_header h;
    h.packet_type    = ptype;
    h.destination_id = dst;
    h.source_id      = src;
    h.vc             = vc;
    h.tag            = tag;
    h.address        = addr;
    h.burst_length   = blen;
    h.status         = status;
    return h;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flit(input string tag, input logic [1:0] valid, input tnoc_flit_type ftype,
                          input logic head, input logic tail, input logic [39:0] data);
    check({tag, ".valid"}, 64'(flit_if.valid), 64'(valid));
    check({tag, ".type"},  64'(flit_if.flit.flit_type), 64'(ftype));
    check({tag, ".head"},  64'(flit_if.flit.head), 64'(head));
    check({tag, ".tail"},  64'(flit_if.flit.tail), 64'(tail));
    check({tag, ".data"},  64'(flit_if.flit.data), 64'(data));
  endtask

  task automatic chk_rdy(input string tag, input logic hdr_rdy, input logic pay_rdy);
    check({tag, ".header_ready"},  64'(pkt_if.header_ready), 64'(hdr_rdy));
    check({tag, ".payload_ready"}, 64'(pkt_if.payload_ready), 64'(pay_rdy));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payload(input logic [31:0] data, input logic [3:0] be,
                             input logic [1:0] status, input logic rlast, input logic last);
    pkt_if.payload.data          = data;
    pkt_if.payload.byte_enable   = be;
    pkt_if.payload.status        = status;
    pkt_if.payload.response_last = rlast;
    pkt_if.payload_last          = last;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rd_req_hdr = make_hdr(TNOC_READ,          4'h3, 4'h1, 2'd1, 6'h05, 32'h12345678, 9'd1, 2'b00);
    wr_req_hdr = make_hdr(TNOC_WRITE,         4'h2, 4'h1, 2'd0, 6'h0A, 32'hA0000040, 9'd4, 2'b00);
    rd_rsp_hdr = make_hdr(TNOC_READ_RESPONSE, 4'h1, 4'h3, 2'd0, 6'h05, 32'h0,        9'd0, 2'b10);
    wr_rsp_hdr = make_hdr(TNOC_RESPONSE,      4'h5, 4'h2, 2'd0, 6'h01, 32'h0,        9'd0, 2'b01);

    // Reset with both valids asserted: nothing may leak out.
    rst_n                = 1'b0;
    pkt_if.header        = rd_req_hdr;
    pkt_if.header_valid  = 1'b1;
    pkt_if.payload_valid = 1'b1;
    set_payload(32'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    flit_if.ready        = 2'b11;
    flit_if.vc_available = 2'b11;
    repeat (2) next_cycle();
    check("reset.valid", 64'(flit_if.valid), 64'(2'b00));
    chk_rdy("reset", 1'b0, 1'b0);
    rst_n                = 1'b1;
    pkt_if.header_valid  = 1'b0;
    pkt_if.payload_valid = 1'b0;

    // Read request on VC1: two header flits, tail on the second.
    next_cycle();
    pkt_if.header        = rd_req_hdr;
    pkt_if.header_valid  = 1'b1;
    pkt_if.payload_valid = 1'b1;
    @(negedge clk);
    chk_flit("rdreq.f0", 2'b10, TNOC_HEADER_FLIT, 1'b1, 1'b0, RD_REQ_F0);
    chk_rdy("rdreq.f0", 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_flit("rdreq.f1", 2'b10, TNOC_HEADER_FLIT, 1'b0, 1'b1, RD_REQ_F1);
    chk_rdy("rdreq.f1", 1'b1, 1'b0);
    next_cycle();
    pkt_if.header_valid  = 1'b0;
    pkt_if.payload_valid = 1'b0;
    @(negedge clk);
    check("rdreq.idle.valid", 64'(flit_if.valid), 64'(2'b00));

    // Write request, burst 4 on VC0.
    next_cycle();
    pkt_if.header       = wr_req_hdr;
    pkt_if.header_valid = 1'b1;
    @(negedge clk);
    chk_flit("wrreq.f0", 2'b01, TNOC_HEADER_FLIT, 1'b1, 1'b0, WR_REQ_F0);
    chk_rdy("wrreq.f0", 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_flit("wrreq.f1", 2'b01, TNOC_HEADER_FLIT, 1'b0, 1'b0, WR_REQ_F1);
    chk_rdy("wrreq.f1", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      pkt_if.payload_valid = 1'b1;
      set_payload(wr_data[i], wr_be[i], 2'b11, 1'b1, (i == 3));
      @(negedge clk);
      chk_flit($sformatf("wrreq.p%0d", i), 2'b01, TNOC_PAYLOAD_FLIT, 1'b0, (i == 3), wr_flit[i]);
      chk_rdy($sformatf("wrreq.p%0d", i), 1'b0, 1'b1);
    end
    next_cycle();
    pkt_if.header_valid  = 1'b0;
    pkt_if.payload_valid = 1'b0;
    set_payload(32'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check("wrreq.idle.valid", 64'(flit_if.valid), 64'(2'b00));

    // Backpressure on VC1 for three cycles while VC0 stays ready.
    next_cycle();
    pkt_if.header       = rd_req_hdr;
    pkt_if.header_valid = 1'b1;
    flit_if.ready       = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_flit($sformatf("stall.c%0d", k), 2'b10, TNOC_HEADER_FLIT, 1'b1, 1'b0, RD_REQ_F0);
      chk_rdy($sformatf("stall.c%0d", k), 1'b0, 1'b0);
      next_cycle();
    end
    flit_if.ready = 2'b11;
    @(negedge clk);
    chk_flit("stall.f0", 2'b10, TNOC_HEADER_FLIT, 1'b1, 1'b0, RD_REQ_F0);
    chk_rdy("stall.f0", 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_flit("stall.f1", 2'b10, TNOC_HEADER_FLIT, 1'b0, 1'b1, RD_REQ_F1);
    chk_rdy("stall.f1", 1'b1, 1'b0);
    next_cycle();
    pkt_if.header_valid = 1'b0;

    // Read response: one header flit then two read payload beats.
    pkt_if.header       = rd_rsp_hdr;
    pkt_if.header_valid = 1'b1;
    @(negedge clk);
    chk_flit("rdrsp.h", 2'b01, TNOC_HEADER_FLIT, 1'b1, 1'b0, RD_RSP_F0);
    chk_rdy("rdrsp.h", 1'b1, 1'b0);
    next_cycle();
    pkt_if.header_valid  = 1'b0;
    pkt_if.payload_valid = 1'b1;
    set_payload(32'h11111111, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk_flit("rdrsp.p0", 2'b01, TNOC_PAYLOAD_FLIT, 1'b0, 1'b0, 40'h0011111111);
    chk_rdy("rdrsp.p0", 1'b0, 1'b1);
    next_cycle();
    set_payload(32'h22222222, 4'hF, 2'b10, 1'b1, 1'b1);
    @(negedge clk);
    chk_flit("rdrsp.p1", 2'b01, TNOC_PAYLOAD_FLIT, 1'b0, 1'b1, 40'h0622222222);
    chk_rdy("rdrsp.p1", 1'b0, 1'b1);
    next_cycle();
    pkt_if.payload_valid = 1'b0;
    set_payload(32'h0, 4'h0, 2'b00, 1'b0, 1'b0);

    // Reset in the middle of a write burst on VC1.
    pkt_if.header       = wr_req_hdr;
    pkt_if.header.vc    = 2'd1;
    pkt_if.header_valid = 1'b1;
    @(negedge clk);
    check("abort.f0.valid", 64'(flit_if.valid), 64'(2'b10));
    next_cycle();
    @(negedge clk);
    check("abort.f1.header_ready", 64'(pkt_if.header_ready), 64'(1'b1));
    next_cycle();
    pkt_if.header_valid  = 1'b0;
    pkt_if.payload_valid = 1'b1;
    set_payload(wr_data[0], wr_be[0], 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check("abort.p0.valid", 64'(flit_if.valid), 64'(2'b10));
    check("abort.p0.payload_ready", 64'(pkt_if.payload_ready), 64'(1'b1));
    next_cycle();
    set_payload(wr_data[1], wr_be[1], 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check("abort.p1.valid", 64'(flit_if.valid), 64'(2'b10));
    rst_n = 1'b0;
    #1;
    check("abort.rst.valid", 64'(flit_if.valid), 64'(2'b00));
    chk_rdy("abort.rst", 1'b0, 1'b0);
    next_cycle();
    rst_n               = 1'b1;
    pkt_if.header       = rd_req_hdr;
    pkt_if.header_valid = 1'b1;
    @(negedge clk);
    chk_flit("abort.new.f0", 2'b10, TNOC_HEADER_FLIT, 1'b1, 1'b0, RD_REQ_F0);
    chk_rdy("abort.new.f0", 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_flit("abort.new.f1", 2'b10, TNOC_HEADER_FLIT, 1'b0, 1'b1, RD_REQ_F1);
    next_cycle();
    pkt_if.payload_valid = 1'b0;

    // Write response immediately followed by a read request.
    pkt_if.header       = wr_rsp_hdr;
    pkt_if.header_valid = 1'b1;
    @(negedge clk);
    chk_flit("b2b.wrrsp", 2'b01, TNOC_HEADER_FLIT, 1'b1, 1'b1, WR_RSP_F0);
    chk_rdy("b2b.wrrsp", 1'b1, 1'b0);
    next_cycle();
    pkt_if.header = rd_req_hdr;
    @(negedge clk);
    chk_flit("b2b.rd.f0", 2'b10, TNOC_HEADER_FLIT, 1'b1, 1'b0, RD_REQ_F0);
    next_cycle();
    @(negedge clk);
    chk_flit("b2b.rd.f1", 2'b10, TNOC_HEADER_FLIT, 1'b0, 1'b1, RD_REQ_F1);
    next_cycle();
    pkt_if.header_valid = 1'b0;
    @(negedge clk);
    check("b2b.idle.valid", 64'(flit_if.valid), 64'(2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
